// File: rtl/gpio_controller_pulse_evt.sv
// GPIO controller on the IO command bus: up to 16 pins with byte-lane access and per-pin output enables.
// Adds synchronised inputs, sticky edge events with an IRQ, and per-pin pulse/clock generation.
module gpio_controller_pulse_evt #(
  parameter int PIN_COUNT      = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int PULSE_PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 async_rst,
  input  logic                 clk_en,
  input  logic                 IO_REQ,
  output logic                 IO_ACK,
  input  logic                 IO_CommandEn,
  input  logic                 IO_ResponseRequested,
  input  logic [3:0]           IO_DestRegIn,
  input  logic [15:0]          IO_DataIn,
  output logic                 IO_CommandResponse,
  output logic                 IO_RegResponseFlag,
  output logic                 IO_MemResponseFlag,
  output logic [3:0]           IO_DestRegOut,
  output logic [15:0]          IO_DataOut,
  input  logic [PIN_COUNT-1:0] GPIO_DIn,
  output logic [PIN_COUNT-1:0] GPIO_DOut,
  output logic [PIN_COUNT-1:0] GPIO_DOutEn,
  output logic                 GPIO_IRQ
);

  localparam int CW = 8 + $clog2(PULSE_PRESCALE);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PULSE = 2'd1, S_CLOCK = 2'd2} pstate_t;

  logic          w_accept;
  logic [3:0]    w_pin;
  logic [3:0]    w_opc;
  logic [7:0]    w_op;
  logic          w_lane;
  logic [CW-1:0] w_load;
  logic [15:0]   w_rdata;

  // Pins beyond PIN_COUNT are padded with constant zeros so lane reads fall out naturally.
  logic [15:0]   w_out;
  logic [15:0]   w_oe;
  logic [15:0]   w_sync;
  logic [15:0]   w_event;
  logic [15:0]   w_event_next;

  logic          r_resp;
  logic          r_reg_flag;
  logic [3:0]    r_dest;
  logic [15:0]   r_data;
  logic          r_irq;

  assign w_accept = IO_REQ & IO_CommandEn & clk_en;
  assign w_pin    = IO_DataIn[15:12];
  assign w_opc    = IO_DataIn[11:8];
  assign w_op     = IO_DataIn[7:0];
  assign w_lane   = w_pin[3];
  assign w_load   = CW'(w_op) * CW'(PULSE_PRESCALE);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pin
      if (gi < PIN_COUNT) begin : g_real
        localparam logic [3:0] PIN_ID  = 4'(gi);
        localparam logic       LANE_ID = 1'(gi / 8);
        localparam int         LBIT    = gi % 8;

        pstate_t                r_state, w_state_next;
        logic [CW-1:0]          r_cnt, w_cnt_next, w_dec;
        logic                   r_out, w_out_next;
        logic                   r_oe, w_oe_next;
        logic [1:0]             r_mode, w_mode_next;
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_hist;
        logic                   r_event;
        logic                   w_bit_hit, w_lane_hit;
        logic                   w_rise, w_fall, w_set, w_clr;

        // Out-of-range pin indices never match a real pin, so they change nothing.
        assign w_bit_hit  = w_accept && (w_pin == PIN_ID);
        assign w_lane_hit = w_accept && (w_lane == LANE_ID);
        assign w_dec      = r_cnt - CW'(1);

        always_comb begin
          w_state_next = r_state;
          w_cnt_next   = r_cnt;
          w_out_next   = r_out;
          w_oe_next    = r_oe;
          w_mode_next  = r_mode;
          if (clk_en) begin
            case (r_state)
              S_PULSE: begin
                w_cnt_next = w_dec;
                if (w_dec == '0) begin
                  w_state_next = S_IDLE;
                  w_out_next   = 1'b0;
                end
              end
              S_CLOCK: w_out_next = ~r_out;
              default: ;
            endcase
          end
          // Commands override whatever the engine did this cycle.
          if (w_bit_hit) begin
            case (w_opc)
              4'd0: begin
                w_state_next = S_IDLE;
                w_out_next   = w_op[0];
              end
              4'd2: w_oe_next = w_op[0];
              4'd8: begin
                if (w_op != 8'd0) begin
                  w_state_next = S_PULSE;
                  w_cnt_next   = w_load;
                  w_out_next   = 1'b1;
                end else begin
                  w_state_next = S_CLOCK;
                  w_out_next   = r_out;
                end
              end
              4'd9: begin
                w_state_next = S_IDLE;
                w_out_next   = ~r_out;
              end
              4'd11: w_mode_next = w_op[1:0];
              default: ;
            endcase
          end
          if (w_lane_hit) begin
            case (w_opc)
              4'd1: begin
                w_state_next = S_IDLE;
                w_out_next   = w_op[LBIT];
              end
              4'd3: w_oe_next = w_op[LBIT];
              default: ;
            endcase
          end
        end

        assign w_rise = r_sync[SYNC_STAGES-1] & ~r_hist;
        assign w_fall = ~r_sync[SYNC_STAGES-1] & r_hist;
        assign w_set  = clk_en & ((r_mode[0] & w_rise) | (r_mode[1] & w_fall));
        assign w_clr  = w_lane_hit && (w_opc == 4'd10);
        // A fresh edge wins over a simultaneous clear.
        assign w_event_next[gi] = (r_event & ~w_clr) | w_set;

        always_ff @(posedge clk or posedge async_rst) begin
          if (async_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_oe    <= 1'b0;
            r_mode  <= 2'b00;
            r_sync  <= '0;
            r_hist  <= 1'b0;
            r_event <= 1'b0;
          end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_out   <= w_out_next;
            r_oe    <= w_oe_next;
            r_mode  <= w_mode_next;
            r_event <= w_event_next[gi];
            if (clk_en) begin
              r_sync <= {r_sync[SYNC_STAGES-2:0], GPIO_DIn[gi]};
              r_hist <= r_sync[SYNC_STAGES-1];
            end
          end
        end

        assign w_out[gi]   = r_out;
        assign w_oe[gi]    = r_oe;
        assign w_sync[gi]  = r_sync[SYNC_STAGES-1];
        assign w_event[gi] = r_event;
      end else begin : g_absent
        assign w_out[gi]        = 1'b0;
        assign w_oe[gi]         = 1'b0;
        assign w_sync[gi]       = 1'b0;
        assign w_event[gi]      = 1'b0;
        assign w_event_next[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    w_rdata = 16'h0000;
    case (w_opc)
      4'd4:  w_rdata = {15'b0, w_out[w_pin]};
      4'd5:  w_rdata = {15'b0, w_sync[w_pin]};
      4'd6:  w_rdata = {8'b0, (w_lane ? w_out[15:8]   : w_out[7:0])};
      4'd7:  w_rdata = {8'b0, (w_lane ? w_sync[15:8]  : w_sync[7:0])};
      4'd10: w_rdata = {8'b0, (w_lane ? w_event[15:8] : w_event[7:0])};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_resp     <= 1'b0;
      r_reg_flag <= 1'b0;
      r_dest     <= 4'h0;
      r_data     <= 16'h0000;
      r_irq      <= 1'b0;
    end else if (clk_en) begin
      r_resp     <= w_accept;
      r_reg_flag <= w_accept & IO_ResponseRequested;
      r_irq      <= |w_event_next;
      if (w_accept) begin
        r_dest <= IO_DestRegIn;
        r_data <= w_rdata;
      end
    end
  end

  assign IO_ACK             = clk_en;
  assign IO_CommandResponse = r_resp;
  assign IO_RegResponseFlag = r_reg_flag;
  assign IO_MemResponseFlag = 1'b0;
  assign IO_DestRegOut      = r_dest;
  assign IO_DataOut         = r_data;
  assign GPIO_DOut          = w_out[PIN_COUNT-1:0];
  assign GPIO_DOutEn        = w_oe[PIN_COUNT-1:0];
  assign GPIO_IRQ           = r_irq;

endmodule

// File: tb/tb_gpio_controller_pulse_evt.sv
// Directed bench for gpio_controller_pulse_evt: a 16-pin instance with prescale 2 and an 8-pin instance
// sharing the command bus, each with its own request line.
module tb_gpio_controller_pulse_evt;

  logic        clk = 1'b0;
  logic        async_rst;
  logic        clk_en;
  logic        req16, req8;
  logic        cmd_en;
  logic        rr;
  logic [3:0]  dest;
  logic [15:0] data_in;
  logic [15:0] din16;
  logic [7:0]  din8;

  logic        ack16, resp16, regf16, memf16, irq16;
  logic [3:0]  dest16;
  logic [15:0] dout_bus16, dout16, oe16;
  logic        ack8, resp8, regf8, memf8, irq8;
  logic [3:0]  dest8;
  logic [15:0] dout_bus8;
  logic [7:0]  dout8, oe8;

  int checks = 0;
  int failures = 0;
  int cnt;
  logic exp_bit;

  always #5 clk = ~clk;

  gpio_controller_pulse_evt #(.PIN_COUNT(16), .SYNC_STAGES(2), .PULSE_PRESCALE(2)) dut (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en),
    .IO_REQ(req16), .IO_ACK(ack16), .IO_CommandEn(cmd_en),
    .IO_ResponseRequested(rr), .IO_DestRegIn(dest), .IO_DataIn(data_in),
    .IO_CommandResponse(resp16), .IO_RegResponseFlag(regf16), .IO_MemResponseFlag(memf16),
    .IO_DestRegOut(dest16), .IO_DataOut(dout_bus16),
    .GPIO_DIn(din16), .GPIO_DOut(dout16), .GPIO_DOutEn(oe16), .GPIO_IRQ(irq16)
  );

  gpio_controller_pulse_evt #(.PIN_COUNT(8), .SYNC_STAGES(2), .PULSE_PRESCALE(1)) dut8 (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en),
    .IO_REQ(req8), .IO_ACK(ack8), .IO_CommandEn(cmd_en),
    .IO_ResponseRequested(rr), .IO_DestRegIn(dest), .IO_DataIn(data_in),
    .IO_CommandResponse(resp8), .IO_RegResponseFlag(regf8), .IO_MemResponseFlag(memf8),
    .IO_DestRegOut(dest8), .IO_DataOut(dout_bus8),
    .GPIO_DIn(din8), .GPIO_DOut(dout8), .GPIO_DOutEn(oe8), .GPIO_IRQ(irq8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=0x%0h", tag, got);
    end
  endtask

  // Called at a negedge; the command is accepted on the next posedge and the task
  // returns at the following negedge, where the registered response is visible.
  task automatic send(input bit to8, input logic [3:0] pin, input logic [3:0] opc,
                      input logic [7:0] op, input logic rq, input logic [3:0] dreg);
    cmd_en  = 1'b1;
    rr      = rq;
    dest    = dreg;
    data_in = {pin, opc, op};
    if (to8) req8 = 1'b1; else req16 = 1'b1;
    @(negedge clk);
    req16  = 1'b0;
    req8   = 1'b0;
    cmd_en = 1'b0;
    rr     = 1'b0;
  endtask

  // Counts consecutive negedge samples with dout16[4] high, starting with the current one.
  task automatic count_high4(output int n);
    n = 0;
    while (dout16[4] && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    async_rst = 1'b1;
    clk_en    = 1'b1;
    req16 = 1'b0; req8 = 1'b0; cmd_en = 1'b0; rr = 1'b0;
    dest = 4'h0; data_in = 16'h0000;
    din16 = 16'h0000; din8 = 8'hFF;
    repeat (2) @(negedge clk);
    check_eq("rst_dout", 32'(dout16), 32'h0);
    check_eq("rst_oe",   32'(oe16),   32'h0);
    check_eq("rst_irq",  32'(irq16),  32'h0);
    check_eq("rst_resp", 32'(resp16), 32'h0);
    async_rst = 1'b0;
    @(negedge clk);

    // Byte writes and registered read-back
    send(0, 4'd0, 4'd3, 8'hFF, 0, 4'd0);
    send(0, 4'd0, 4'd1, 8'hA5, 0, 4'd0);
    check_eq("oe_lane0",   32'(oe16[7:0]),   32'hFF);
    check_eq("dout_lane0", 32'(dout16[7:0]), 32'hA5);
    send(0, 4'd0, 4'd6, 8'h00, 1, 4'd3);
    check_eq("rd_resp",  32'(resp16),     32'h1);
    check_eq("rd_regf",  32'(regf16),     32'h1);
    check_eq("rd_dest",  32'(dest16),     32'h3);
    check_eq("rd_data",  32'(dout_bus16), 32'h00A5);
    check_eq("rd_memf",  32'(memf16),     32'h0);
    @(negedge clk);
    check_eq("resp_drop", 32'(resp16), 32'h0);
    send(0, 4'd8, 4'd1, 8'h3C, 0, 4'd0);
    send(0, 4'd10, 4'd4, 8'h00, 0, 4'd5);
    check_eq("rdbit_p10", 32'(dout_bus16), 32'h1);
    check_eq("regf_norr", 32'(regf16),     32'h0);

    // Pulse pin 4, op 5, prescale 2 -> 10 cycles
    send(0, 4'd4, 4'd8, 8'd5, 0, 4'd0);
    count_high4(cnt);
    check_eq("pulse_len10", 32'(cnt), 32'd10);
    check_eq("pulse_low",   32'(dout16[4]), 32'h0);
    send(0, 4'd4, 4'd8, 8'd5, 0, 4'd0);
    repeat (3) @(negedge clk);
    send(0, 4'd4, 4'd8, 8'd3, 0, 4'd0);
    count_high4(cnt);
    check_eq("pulse_restart6", 32'(cnt), 32'd6);

    // Clock mode on pin 2 (currently 1 from 0xA5), then WriteBit stops it
    send(0, 4'd2, 4'd8, 8'd0, 0, 4'd0);
    exp_bit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("clk_toggle%0d", i), 32'(dout16[2]), 32'(exp_bit));
      exp_bit = ~exp_bit;
      @(negedge clk);
    end
    send(0, 4'd2, 4'd0, 8'd1, 0, 4'd0);
    check_eq("wb_steady0", 32'(dout16[2]), 32'h1);
    @(negedge clk);
    check_eq("wb_steady1", 32'(dout16[2]), 32'h1);
    @(negedge clk);
    check_eq("wb_steady2", 32'(dout16[2]), 32'h1);

    // Rising-edge event on pin 9
    send(0, 4'd9, 4'd11, 8'h01, 0, 4'd0);
    din16[9] = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("irq_early", 32'(irq16), 32'h0);
    @(negedge clk);
    check_eq("irq_set", 32'(irq16), 32'h1);
    send(0, 4'd9, 4'd5, 8'h00, 0, 4'd0);
    check_eq("rdpin_p9", 32'(dout_bus16), 32'h1);
    send(0, 4'd8, 4'd7, 8'h00, 0, 4'd0);
    check_eq("rdpin_lane1", 32'(dout_bus16), 32'h0002);
    send(0, 4'd8, 4'd10, 8'h00, 0, 4'd0);
    check_eq("rdclr_data", 32'(dout_bus16), 32'h0002);
    check_eq("irq_clear",  32'(irq16),      32'h0);
    send(0, 4'd8, 4'd10, 8'h00, 0, 4'd0);
    check_eq("rdclr_empty", 32'(dout_bus16), 32'h0000);
    din16[9] = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("fall_ignored", 32'(irq16), 32'h0);

    // 8-pin instance: upper lane and pins are absent
    send(1, 4'd8, 4'd1, 8'hFF, 0, 4'd0);
    check_eq("p8_wb_lane1", 32'(dout8), 32'h00);
    send(1, 4'd0, 4'd7, 8'h00, 0, 4'd0);
    check_eq("p8_rdpin_lane0", 32'(dout_bus8), 32'h00FF);
    send(1, 4'd12, 4'd5, 8'h00, 0, 4'd0);
    check_eq("p8_rdpin12", 32'(dout_bus8), 32'h0000);
    send(1, 4'd0, 4'd7, 8'h00, 0, 4'd0);
    send(1, 4'd0, 4'd13, 8'h00, 0, 4'd0);
    check_eq("p8_op13_resp", 32'(resp8),     32'h1);
    check_eq("p8_op13_data", 32'(dout_bus8), 32'h0000);

    // clk_en low freezes an active pulse
    send(0, 4'd4, 4'd8, 8'd5, 0, 4'd0);
    repeat (2) @(negedge clk);
    clk_en = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("hold_dout4", 32'(dout16[4]), 32'h1);
    check_eq("hold_ack",   32'(ack16),     32'h0);
    clk_en = 1'b1;
    count_high4(cnt);
    check_eq("hold_remaining8", 32'(cnt), 32'd8);

    // Asynchronous reset mid-pulse
    send(0, 4'd4, 4'd8, 8'd5, 0, 4'd0);
    check_eq("pre_rst_high", 32'(dout16[4]), 32'h1);
    #2;
    async_rst = 1'b1;
    #1;
    check_eq("async_rst_dout", 32'(dout16), 32'h0);
    check_eq("async_rst_oe",   32'(oe16),   32'h0);
    @(negedge clk);
    async_rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_controller_pulse_evt.md
Name: gpio_controller_pulse_evt

Overview:
Parametrised successor to the 8-pin GPIO controller on the IO command bus. It supports up to 16 pins, byte-lane access, and per-pin output-enable control. It adds synchronised inputs, sticky edge-event capture with an IRQ, and prescaled pulse/clock generation with a cancellable per-pin counter. Responses are registered, with 1-cycle latency, and return on the standard register-response path.

Parameters:
PIN_COUNT, 16, number of GPIO pins (legal range 1..16).
SYNC_STAGES, 2, input synchroniser flops per pin (minimum 2).
PULSE_PRESCALE, 1, clk_en cycles per pulse-length unit (minimum 1).

Ports:
clk  in  1  clock
async_rst  in  1  reset; asynchronous, active-high
clk_en  in  1  global clock enable; all state advances only when high
IO_REQ  in  1  command request
IO_ACK  out  1  = clk_en
IO_CommandEn  in  1  command valid
IO_ResponseRequested  in  1  caller wants register writeback
IO_DestRegIn  in  4  destination register tag
IO_DataIn  in  16  [15:12] pin index, [11:8] opcode, [7:0] operand
IO_CommandResponse  out  1  registered response strobe
IO_RegResponseFlag  out  1  registered: response strobe AND captured ResponseRequested
IO_MemResponseFlag  out  1  constant 0
IO_DestRegOut  out  4  registered copy of DestRegIn
IO_DataOut  out  16  registered read data
GPIO_DIn  in  PIN_COUNT  pad inputs
GPIO_DOut  out  PIN_COUNT  pad outputs
GPIO_DOutEn  out  PIN_COUNT  pad output enables
GPIO_IRQ  out  1  OR of all sticky event flags

Behaviour:
- Accept: IO_REQ && IO_CommandEn && clk_en. All state changes and response capture happen on that edge.
- Response: asserted exactly one clk_en cycle after the accept, then deasserted.
- Reset: every register clears to 0, including all outputs, pulse counters, events and edge modes.
- Lane: lane = pin[3] selects pins 8*lane .. 8*lane+7. Lane bits at or beyond PIN_COUNT are ignored on write and read as 0.
- Out-of-range pin: a bit opcode with pin >= PIN_COUNT changes no state, reads 0 and still responds.
- Opcodes (operand = op):
  - 0 WriteBit: out[pin] = op[0].
  - 1 WriteByte: out lane = op.
  - 2 SetOE: oe[pin] = op[0].
  - 3 WriteOEByte: oe lane = op.
  - 4 ReadOutBit: data = {15'b0, out[pin]}.
  - 5 ReadPinBit: data = {15'b0, synchronised pin}.
  - 6 ReadOutByte: data = {8'b0, out lane}.
  - 7 ReadPinByte: data = {8'b0, synchronised lane}.
  - 8 Pulse: op != 0 drives out[pin] = 1 for op*PULSE_PRESCALE clk_en cycles, then 0. op == 0 enters clock mode: out[pin] toggles every clk_en cycle.
  - 9 ToggleBit: out[pin] inverted.
  - 10 ReadClrEvents: data = {8'b0, event lane}; clears that lane's flags.
  - 11 SetEdgeMode: mode[pin] = op[1:0] (00 off, 01 rise, 10 fall, 11 both).
  - 12..15: reserved; no state change, data 0.
- Non-read opcodes return data 0.
- Pulse engine:
  - Per-pin state machine IDLE / PULSE / CLOCK, with a 8+log2(PRESCALE) bit down-counter.
  - PULSE -> IDLE when the counter reaches 0.
  - Any opcode 0, 1, 8 or 9 hitting the pin forces the state to IDLE first. A new Pulse restarts the counter, and the command value wins.
- Inputs: GPIO_DIn passes through SYNC_STAGES flops plus one history flop.
  - Read latency from pad change to visible value is SYNC_STAGES cycles.
  - An edge matching mode[pin] sets event[pin] (sticky).
  - A new edge in the same cycle as ReadClrEvents on that pin leaves the flag set; the read returns the pre-clear value.
- GPIO_IRQ: registered, equal to |event.
- Outputs: GPIO_DOut = out register and GPIO_DOutEn = oe register, both direct from flops.
- Reset mid-pulse: the block returns to IDLE and the pin goes low immediately (asynchronous).
- clk_en low: counters, synchronisers and the response strobe all hold.

Test Plan:
- Reset, then WriteOEByte lane0 0xFF and WriteByte lane0 0xA5 -> DOutEn[7:0] = 0xFF, DOut[7:0] = 0xA5. ReadOutByte with ResponseRequested=1, DestReg=3 -> one cycle later CommandResponse=1, RegResponseFlag=1, DestRegOut=3, DataOut=0x00A5.
- Pulse pin 4, op=5, PRESCALE=2 -> DOut[4] high for exactly 10 clk_en cycles, then low. A second Pulse op=3 at cycle 4 restarts -> high for 6 more cycles.
- Pulse pin 2, op=0 -> DOut[2] toggles each cycle. WriteBit pin2 op=1 -> steady 1, no toggle.
- SetEdgeMode pin 9 = 01, drive DIn[9] 0->1 -> IRQ high after SYNC_STAGES+1 cycles. ReadClrEvents lane1 -> DataOut=0x0002, and IRQ drops the following cycle.
- PIN_COUNT=8: WriteByte lane1 0xFF -> no change. ReadPinBit pin 12 -> 0. Opcode 13 -> CommandResponse=1, DataOut=0.
- Hold clk_en=0 during an active pulse -> counter frozen and DOut unchanged. Assert async_rst mid-pulse -> DOut=0 with no clock edge.
